// File: rtl/uart_rx_sequencer.sv
// Oversampling UART receiver: start qualification, mid-bit data sampling (LSB first),
// stop check, and a one-entry valid/ready holding register with framing/overrun flags.
module uart_rx_sequencer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 i_CLK,
    input  logic                 i_RST_N,
    input  logic                 i_RX,
    input  logic                 i_READY,
    output logic                 o_VALID,
    output logic [DATA_BITS-1:0] o_DATA,
    output logic                 o_FRAME_ERR,
    output logic                 o_OVERRUN,
    output logic                 o_BUSY
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    logic                 rx_meta_q, rx_sync_q, rx_s;
    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic                 deliver_s, frame_s;

    assign rx_s = rx_sync_q;

    // State, counters, synchronizer and registered outputs.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= S_IDLE;
            baud_q      <= {BAUD_W{1'b0}};
            bit_q       <= {BIT_W{1'b0}};
            shift_q     <= {DATA_BITS{1'b0}};
            valid_q     <= 1'b0;
            data_q      <= {DATA_BITS{1'b0}};
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_meta_q   <= i_RX;
            rx_sync_q   <= rx_meta_q;
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    // Frame sequencing: next state, bit/baud counters, shift register, delivery strobes.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        deliver_s = 1'b0;
        frame_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_q == BAUD_MID) begin
                    if (!rx_s) begin
                        state_d = S_DATA;
                        bit_d   = {BIT_W{1'b0}};
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                        bit_d   = {BIT_W{1'b0}};
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    if (rx_s) begin
                        deliver_s = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_s   = 1'b1;
                        state_d   = S_WAIT_HIGH;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_WAIT_HIGH: begin
                // Hold off until the line returns high so a break cannot retrigger.
                if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_HIGH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            baud_d = {BAUD_W{1'b0}};
        end else if (baud_q == BAUD_LAST) begin
            baud_d = {BAUD_W{1'b0}};
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end
    end

    // Holding register handshake and error pulses.
    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        overrun_d   = 1'b0;
        frame_err_d = frame_s;
        busy_d      = (state_d != S_IDLE);
        if (deliver_s) begin
            if (!valid_q || i_READY) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && i_READY) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    assign o_VALID     = valid_q;
    assign o_DATA      = data_q;
    assign o_FRAME_ERR = frame_err_q;
    assign o_OVERRUN   = overrun_q;
    assign o_BUSY      = busy_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer: one task per scenario, inline checks.
module tb_uart_rx_sequencer;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          ready = 1'b1;
    logic          o_valid;
    logic [DB-1:0] o_data;
    logic          o_frame_err;
    logic          o_overrun;
    logic          o_busy;

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int fall_cyc = 0;
    int valid_cyc = 0;
    int xfer_cnt = 0;
    logic [DB-1:0] last_xfer = 8'h00;
    int frame_cnt = 0;
    int overrun_cnt = 0;
    int both_cnt = 0;
    int busy_cyc = 0;
    int unstable_cnt = 0;
    int last_rise_cyc = 0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic [DB-1:0] prev_data = 8'h00;

    uart_rx_sequencer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .i_CLK      (clk),
        .i_RST_N    (rst_n),
        .i_RX       (rx),
        .i_READY    (ready),
        .o_VALID    (o_valid),
        .o_DATA     (o_data),
        .o_FRAME_ERR(o_frame_err),
        .o_OVERRUN  (o_overrun),
        .o_BUSY     (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid) valid_cyc <= valid_cyc + 1;
            if (o_valid && ready) begin
                xfer_cnt  <= xfer_cnt + 1;
                last_xfer <= o_data;
            end
            if (o_frame_err) frame_cnt <= frame_cnt + 1;
            if (o_overrun) overrun_cnt <= overrun_cnt + 1;
            if (o_frame_err && o_overrun) both_cnt <= both_cnt + 1;
            if (o_busy) busy_cyc <= busy_cyc + 1;
            if (o_valid && prev_valid && !prev_ready && o_data != prev_data)
                unstable_cnt <= unstable_cnt + 1;
            if (o_valid && !prev_valid) last_rise_cyc <= cyc;
        end
        prev_valid <= o_valid;
        prev_ready <= ready;
        prev_data  <= o_data;
    end

    task automatic send_frame(input logic [DB-1:0] b, input logic stop_bit);
        @(posedge clk); #1;
        rx = 1'b0;
        fall_cyc = cyc;
        for (int i = 0; i < DB; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rx = stop_bit;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({o_valid, o_data, o_frame_err, o_overrun, o_busy} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b d=%h fe=%b ov=%b busy=%b required all 0",
                     o_valid, o_data, o_frame_err, o_overrun, o_busy);
        end
        idle(3);
        rst_n = 1'b1;
        idle(5);
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b valid=%b required 0 0", o_busy, o_valid);
        end
    endtask

    task automatic test_single_byte;
        int v0, x0, f0, o0;
        v0 = valid_cyc; x0 = xfer_cnt; f0 = frame_cnt; o0 = overrun_cnt;
        ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        idle(10);
        total++;
        if (xfer_cnt - x0 != 1 || last_xfer !== 8'hA5) begin
            bad++;
            $display("FAIL single_data: got n=%0d data=%h required n=1 data=a5", xfer_cnt - x0, last_xfer);
        end
        total++;
        if (valid_cyc - v0 != 1) begin
            bad++;
            $display("FAIL single_valid_width: got %0d cycles required 1", valid_cyc - v0);
        end
        total++;
        if (last_rise_cyc - fall_cyc < 154 || last_rise_cyc - fall_cyc > 156) begin
            bad++;
            $display("FAIL single_latency: got %0d cycles required 155 +/-1", last_rise_cyc - fall_cyc);
        end
        total++;
        if (frame_cnt != f0 || overrun_cnt != o0) begin
            bad++;
            $display("FAIL single_flags: got fe=%0d ov=%0d required 0 0", frame_cnt - f0, overrun_cnt - o0);
        end
    endtask

    task automatic test_glitch;
        int v0, b0, f0, o0;
        v0 = valid_cyc; b0 = busy_cyc; f0 = frame_cnt; o0 = overrun_cnt;
        @(posedge clk); #1 rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        total++;
        if (busy_cyc - b0 < 7 || busy_cyc - b0 > 9) begin
            bad++;
            $display("FAIL glitch_busy: got %0d busy cycles required 8 +/-1", busy_cyc - b0);
        end
        total++;
        if (valid_cyc != v0 || frame_cnt != f0 || overrun_cnt != o0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL glitch_quiet: got v=%0d fe=%0d ov=%0d busy=%b required 0 0 0 0",
                     valid_cyc - v0, frame_cnt - f0, overrun_cnt - o0, o_busy);
        end
    endtask

    task automatic test_frame_error;
        int v0, x0, f0, lows;
        v0 = valid_cyc; x0 = xfer_cnt; f0 = frame_cnt; lows = 0;
        ready = 1'b1;
        send_frame(8'h3C, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_busy !== 1'b1) lows++;
        end
        total++;
        if (lows != 0) begin
            bad++;
            $display("FAIL break_busy: got %0d idle cycles during break required 0", lows);
        end
        @(posedge clk); #1 rx = 1'b1;
        idle(20);
        total++;
        if (frame_cnt - f0 != 1 || valid_cyc != v0) begin
            bad++;
            $display("FAIL frame_err: got fe=%0d valid=%0d required 1 0", frame_cnt - f0, valid_cyc - v0);
        end
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL break_release: got busy=%b required 0", o_busy);
        end
        send_frame(8'h81, 1'b1);
        idle(10);
        total++;
        if (xfer_cnt - x0 != 1 || last_xfer !== 8'h81 || frame_cnt - f0 != 1) begin
            bad++;
            $display("FAIL after_break_data: got n=%0d data=%h fe=%0d required 1 81 1",
                     xfer_cnt - x0, last_xfer, frame_cnt - f0);
        end
    endtask

    task automatic test_overrun;
        int x0, o0, u0;
        x0 = xfer_cnt; o0 = overrun_cnt; u0 = unstable_cnt;
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(10);
        @(negedge clk);
        total++;
        if (o_valid !== 1'b1 || o_data !== 8'h11) begin
            bad++;
            $display("FAIL overrun_hold: got v=%b data=%h required 1 11", o_valid, o_data);
        end
        total++;
        if (overrun_cnt - o0 != 1 || unstable_cnt != u0 || xfer_cnt != x0) begin
            bad++;
            $display("FAIL overrun_pulse: got ov=%0d unstable=%0d xfer=%0d required 1 0 0",
                     overrun_cnt - o0, unstable_cnt - u0, xfer_cnt - x0);
        end
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (o_valid !== 1'b0 || xfer_cnt - x0 != 1 || last_xfer !== 8'h11) begin
            bad++;
            $display("FAIL overrun_drain: got v=%b n=%0d data=%h required 0 1 11",
                     o_valid, xfer_cnt - x0, last_xfer);
        end
    endtask

    task automatic test_back_to_back;
        int x0, o0;
        ready = 1'b0;
        send_frame(8'h55, 1'b1);
        idle(5);
        x0 = xfer_cnt; o0 = overrun_cnt;
        fork
            send_frame(8'h66, 1'b1);
            begin
                @(negedge rx);
                repeat (154) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
            end
        join
        idle(5);
        @(negedge clk);
        total++;
        if (xfer_cnt - x0 != 1 || last_xfer !== 8'h55) begin
            bad++;
            $display("FAIL b2b_transfer: got n=%0d data=%h required 1 55", xfer_cnt - x0, last_xfer);
        end
        total++;
        if (o_valid !== 1'b1 || o_data !== 8'h66 || overrun_cnt != o0) begin
            bad++;
            $display("FAIL b2b_new_byte: got v=%b data=%h ov=%0d required 1 66 0",
                     o_valid, o_data, overrun_cnt - o0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int x0, f0;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                @(negedge rx);
                repeat (88) @(posedge clk);
                #2;
                total++;
                if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
                    bad++;
                    $display("FAIL pre_reset: got v=%b busy=%b required 1 1", o_valid, o_busy);
                end
                #1 rst_n = 1'b0;
                #1;
                total++;
                if ({o_valid, o_data, o_frame_err, o_overrun, o_busy} !== 12'h000) begin
                    bad++;
                    $display("FAIL async_reset: got v=%b d=%h fe=%b ov=%b busy=%b required all 0",
                             o_valid, o_data, o_frame_err, o_overrun, o_busy);
                end
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        idle(20);
        ready = 1'b1;
        x0 = xfer_cnt; f0 = frame_cnt;
        send_frame(8'h0F, 1'b1);
        idle(10);
        total++;
        if (xfer_cnt - x0 != 1 || last_xfer !== 8'h0F || frame_cnt != f0) begin
            bad++;
            $display("FAIL post_reset_data: got n=%0d data=%h fe=%0d required 1 0f 0",
                     xfer_cnt - x0, last_xfer, frame_cnt - f0);
        end
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_glitch;
        test_frame_error;
        test_overrun;
        test_back_to_back;
        test_reset_mid_frame;
        total++;
        if (both_cnt != 0) begin
            bad++;
            $display("FAIL exclusive_flags: got %0d cycles with both flags required 0", both_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
